// File: rtl/ra_stack_if.sv
// Control-unit <-> return-address-stack bus: push/pop requests in, restore strobes,
// popped RA and occupancy/error status out.
interface ra_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  // push/pop are single-cycle requests sampled on each posedge with no back-pressure:
  // the stack always consumes them, rejected operations are reported via the sticky
  // overflow/underflow flags. restore/raWrite qualify RArestore for exactly one cycle.
  logic                       push;
  logic                       pop;
  logic [WIDTH-1:0]           RA_in;
  logic                       clearErr;
  logic [WIDTH-1:0]           RArestore;
  logic                       restore;
  logic                       raWrite;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output push, pop, RA_in, clearErr,
    input  RArestore, restore, raWrite, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, RA_in, clearErr,
    output RArestore, restore, raWrite, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/ra_stack.sv
// Hardware return-address stack feeding the RA restore path of the PC block.
// Optional RASTK_WRAP_EN: push on full overwrites the oldest entry instead of overflowing.
module ra_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  ra_stack_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    tp;
  logic [AW-1:0]    top_idx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra_restore_q;
  logic             restore_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             is_empty;
  logic             is_full;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;

  assign top_idx  = tp - AW'(1);
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  // Entry write port: a combined push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = tp;
    if (!reset && bus.push) begin
      if (bus.pop && !is_empty) begin
        mem_we   = 1'b1;
        mem_addr = top_idx;
      end else if (bus.pop || !is_full) begin
        mem_we   = 1'b1;
      end else begin
`ifdef RASTK_WRAP_EN
        mem_we   = 1'b1;
`else
        mem_we   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= bus.RA_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp           <= '0;
      cnt          <= '0;
      ra_restore_q <= '0;
      restore_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      restore_q <= 1'b0;
      // Clear first so an error raised in the same cycle wins.
      if (bus.clearErr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (bus.push && bus.pop) begin
        if (is_empty) begin
          tp          <= tp + AW'(1);
          cnt         <= CW'(1);
          underflow_q <= 1'b1;
        end else begin
          ra_restore_q <= mem[top_idx];
          restore_q    <= 1'b1;
        end
      end else if (bus.push) begin
        if (!is_full) begin
          tp  <= tp + AW'(1);
          cnt <= cnt + CW'(1);
        end else begin
`ifdef RASTK_WRAP_EN
          tp <= tp + AW'(1);
`else
          overflow_q <= 1'b1;
`endif
        end
      end else if (bus.pop) begin
        if (!is_empty) begin
          ra_restore_q <= mem[top_idx];
          restore_q    <= 1'b1;
          tp           <= top_idx;
          cnt          <= cnt - CW'(1);
        end else begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.RArestore = ra_restore_q;
  assign bus.restore   = restore_q;
  assign bus.raWrite   = restore_q;
  assign bus.count     = cnt;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_ra_stack.sv
// Directed self-checking bench for ra_stack; expectations follow RASTK_WRAP_EN when defined.
module tb_ra_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [WIDTH-1:0] exp_q[$];

  ra_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ra_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the sampling edge.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    bus.push     = p;
    bus.pop      = q;
    bus.RA_in    = d;
    bus.clearErr = c;
    @(posedge clk);
    #1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.clearErr = 1'b0;
  endtask

  // Pop once and compare against the head of the expected queue.
  task automatic pop_expect(input string tag);
    logic [WIDTH-1:0] e;
    step(1'b0, 1'b1, '0, 1'b0);
    e = exp_q.pop_front();
    check({tag, "_val"}, bus.RArestore, e);
    check({tag, "_restore"}, bus.restore, 1'b1);
    check({tag, "_rawrite"}, bus.raWrite, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.RA_in = '0; bus.clearErr = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;

    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_restore", bus.restore, 0);
    check("rst_rawrite", bus.raWrite, 0);
    check("rst_rarestore", bus.RArestore, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_udf", bus.underflow, 0);

    // basic LIFO with back-to-back pops
    step(1'b1, 1'b0, 16'h0011, 1'b0);
    step(1'b1, 1'b0, 16'h0022, 1'b0);
    step(1'b1, 1'b0, 16'h0033, 1'b0);
    check("push3_count", bus.count, 3);
    check("push3_restore", bus.restore, 0);
    exp_q = '{16'h0033, 16'h0022, 16'h0011};
    pop_expect("lifo0");
    pop_expect("lifo1");
    pop_expect("lifo2");
    check("lifo_count", bus.count, 0);
    check("lifo_empty", bus.empty, 1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("idle_restore", bus.restore, 0);

    // pop on empty
    step(1'b0, 1'b1, '0, 1'b0);
    check("udf_restore", bus.restore, 0);
    check("udf_rawrite", bus.raWrite, 0);
    check("udf_hold", bus.RArestore, 16'h0011);
    check("udf_flag", bus.underflow, 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("udf_clear", bus.underflow, 0);
    step(1'b0, 1'b1, '0, 1'b1);
    check("udf_set_wins", bus.underflow, 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("udf_clear2", bus.underflow, 0);

    // push 1..9 into an 8-deep stack
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 8);
`ifdef RASTK_WRAP_EN
    check("fill_ovf", bus.overflow, 0);
    exp_q = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
`else
    check("fill_ovf", bus.overflow, 1);
    exp_q = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
`endif
    for (int i = 0; i < 8; i++) pop_expect($sformatf("drain%0d", i));
    check("drain_empty", bus.empty, 1);
    check("drain_udf_before", bus.underflow, 0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("drain_udf", bus.underflow, 1);
    check("drain_no_strobe", bus.restore, 0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("drain_clear", bus.overflow | bus.underflow, 0);

    // simultaneous push+pop on a non-empty stack replaces the top
    step(1'b1, 1'b0, 16'h000A, 1'b0);
    step(1'b1, 1'b0, 16'h000B, 1'b0);
    step(1'b1, 1'b1, 16'h000C, 1'b0);
    check("swap_val", bus.RArestore, 16'h000B);
    check("swap_restore", bus.restore, 1);
    check("swap_count", bus.count, 2);
    check("swap_ovf", bus.overflow, 0);
    exp_q = '{16'h000C, 16'h000A};
    pop_expect("swap_pop0");
    pop_expect("swap_pop1");
    check("swap_empty", bus.empty, 1);

    // simultaneous push+pop on an empty stack: push accepted, underflow raised
    step(1'b1, 1'b1, 16'h0042, 1'b0);
    check("ppe_count", bus.count, 1);
    check("ppe_udf", bus.underflow, 1);
    check("ppe_restore", bus.restore, 0);
    check("ppe_hold", bus.RArestore, 16'h000A);
    exp_q = '{16'h0042};
    pop_expect("ppe_pop");

    // reset right after a pop cuts the strobe and clears the sticky flag
    step(1'b1, 1'b0, 16'h0005, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("rp_val", bus.RArestore, 16'h0005);
    check("rp_restore", bus.restore, 1);
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    check("rp_restore_off", bus.restore, 0);
    check("rp_rawrite_off", bus.raWrite, 0);
    check("rp_rarestore", bus.RArestore, 0);
    check("rp_count", bus.count, 0);
    check("rp_flags", bus.overflow | bus.underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
